// File: rtl/gpio_slave.sv
// Memory-mapped GPIO slave: direction/output registers, synchronised inputs,
// per-pin edge interrupts with W1C status and a registered irq. GPIO_DEBOUNCE_EN adds an input filter.
module gpio_slave #(
  parameter int unsigned GPIO_NUM        = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  input  logic [GPIO_NUM-1:0] gpio_i,
  output logic [GPIO_NUM-1:0] gpio_o,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  output logic                irq_o
);

  localparam logic [7:0] OFS_DIR  = 8'h00;
  localparam logic [7:0] OFS_OUT  = 8'h04;
  localparam logic [7:0] OFS_IN   = 8'h08;
  localparam logic [7:0] OFS_IE   = 8'h0C;
  localparam logic [7:0] OFS_EDGE = 8'h10;
  localparam logic [7:0] OFS_IS   = 8'h14;

  logic [GPIO_NUM-1:0] dir_q, out_q, ie_q, edge_sel_q, is_q, prev_q;
  logic                irq_q;
  logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_NUM-1:0] sync_c, in_c, ev_c, wd_c, rdata_c, clr_c;
  logic [7:0]          ofs_c;
  logic                sel_c, wr_c;
  logic                unused_ok;

  // Top nibble is stripped by the bus; upper data bits beyond GPIO_NUM are don't-care.
  assign unused_ok = ^{addr_i[31:28], data_i, 1'(DEBOUNCE_CYCLES)};

  assign sel_c = (addr_i[27:8] == 20'd0) && (addr_i[1:0] == 2'd0);
  assign ofs_c = addr_i[7:0];
  assign wr_c  = we_i && sel_c;
  assign wd_c  = data_i[GPIO_NUM-1:0];
  assign clr_c = (wr_c && (ofs_c == OFS_IS)) ? wd_c : '0;

  // Input synchroniser chain
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CNT_W-1:0]    cnt_q [GPIO_NUM];
  logic [GPIO_NUM-1:0] in_q;

  // IN follows sync only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_q <= '0;
      for (int unsigned b = 0; b < GPIO_NUM; b++) cnt_q[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < GPIO_NUM; b++) begin
        if (sync_c[b] == in_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          in_q[b]  <= sync_c[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  assign in_c = in_q;
`else
  assign in_c = sync_c;
`endif

  assign ev_c = (edge_sel_q & ~in_c & prev_q) | (~edge_sel_q & in_c & ~prev_q);

  // Register file, interrupt status and irq
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q      <= '0;
      out_q      <= '0;
      ie_q       <= '0;
      edge_sel_q <= '0;
      is_q       <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_c) begin
        case (ofs_c)
          OFS_DIR:  dir_q      <= wd_c;
          OFS_OUT:  out_q      <= wd_c;
          OFS_IE:   ie_q       <= wd_c;
          OFS_EDGE: edge_sel_q <= wd_c;
          default:  ;
        endcase
      end
      is_q   <= (is_q & ~clr_c) | ev_c;
      prev_q <= in_c;
      irq_q  <= |(is_q & ie_q);
    end
  end

  // Combinational read mux
  always_comb begin
    rdata_c = '0;
    if (sel_c) begin
      case (ofs_c)
        OFS_DIR:  rdata_c = dir_q;
        OFS_OUT:  rdata_c = out_q;
        OFS_IN:   rdata_c = in_c;
        OFS_IE:   rdata_c = ie_q;
        OFS_EDGE: rdata_c = edge_sel_q;
        OFS_IS:   rdata_c = is_q;
        default:  rdata_c = '0;
      endcase
    end
  end

  assign data_o    = 32'(rdata_c);
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_slave.sv
// Self-checking bench for gpio_slave: directed register/interrupt scenarios
// followed by randomized traffic checked against a behavioural model.
module tb_gpio_slave;

  localparam int N  = 16;
  localparam int S  = 2;
  localparam int DC = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int XL = DC;
`else
  localparam int XL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   addr = '0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   data_o;
  logic [N-1:0]  gpio = '0;
  logic [N-1:0]  gpio_o, gpio_oe_o;
  logic          irq_o;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   last_rd;

  // Reference model state
  logic [N-1:0]  m_dir, m_out, m_ie, m_edge, m_is, m_prev, m_inf;
  logic          m_irq;
  logic [N-1:0]  m_sq [S];
  int            m_run [N];

  gpio_slave #(.GPIO_NUM(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .we_i(we), .data_i(wdata), .data_o(data_o),
    .gpio_i(gpio), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a, input logic [7:0] off);
    return (a[27:8] == 20'd0) && (a[1:0] == 2'd0) && (a[7:0] == off);
  endfunction

  function automatic logic [N-1:0] m_in();
`ifdef GPIO_DEBOUNCE_EN
    return m_inf;
`else
    return m_sq[S-1];
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_hit(a, 8'h00)) return 32'(m_dir);
    if (m_hit(a, 8'h04)) return 32'(m_out);
    if (m_hit(a, 8'h08)) return 32'(m_in());
    if (m_hit(a, 8'h0C)) return 32'(m_ie);
    if (m_hit(a, 8'h10)) return 32'(m_edge);
    if (m_hit(a, 8'h14)) return 32'(m_is);
    return 32'd0;
  endfunction

  task automatic m_reset();
    {m_dir, m_out, m_ie, m_edge, m_is, m_prev, m_inf} = '0;
    m_irq = 1'b0;
    for (int i = 0; i < S; i++) m_sq[i] = '0;
    for (int b = 0; b < N; b++) m_run[b] = 0;
  endtask

  // One clock edge of the reference behaviour
  task automatic m_step(input logic r, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [N-1:0] g);
    logic [N-1:0] cur, ev, clr;
    if (!r) begin
      m_reset();
      return;
    end
    cur = m_in();
    for (int b = 0; b < N; b++)
      ev[b] = (cur[b] != m_prev[b]) && (cur[b] == !m_edge[b]);
    m_irq = |(m_is & m_ie);
    clr = (w && m_hit(a, 8'h14)) ? d[N-1:0] : '0;
    m_is = (m_is & ~clr) | ev;
    if (w && m_hit(a, 8'h00)) m_dir  = d[N-1:0];
    if (w && m_hit(a, 8'h04)) m_out  = d[N-1:0];
    if (w && m_hit(a, 8'h0C)) m_ie   = d[N-1:0];
    if (w && m_hit(a, 8'h10)) m_edge = d[N-1:0];
    m_prev = cur;
    // Filtered value flips after DC consecutive disagreeing cycles
    for (int b = 0; b < N; b++) begin
      if (m_sq[S-1][b] != m_inf[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DC) begin
          m_inf[b] = m_sq[S-1][b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    for (int i = S - 1; i > 0; i--) m_sq[i] = m_sq[i-1];
    m_sq[0] = g;
  endtask

  // Drive one bus cycle, check the combinational read, clock it, check outputs
  task automatic cycle(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [N-1:0] g);
    rst = r; addr = a; we = w; wdata = d; gpio = g;
    #1;
    last_rd = data_o;
    chk($sformatf("rdata@%08h", a), data_o, m_read(a));
    @(posedge clk);
    m_step(r, a, w, d, g);
    #1;
    chk("gpio_o", 32'(gpio_o), 32'(m_out));
    chk("gpio_oe_o", 32'(gpio_oe_o), 32'(m_dir));
    chk("irq_o", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, 1'b1, d, gpio);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, a, 1'b0, 32'h0, gpio);
  endtask

  initial begin
    logic [31:0] ra;
    logic [N-1:0] g;
    m_reset();

    // Reset, with a write attempt that must be discarded
    cycle(1'b0, 32'h0, 1'b1, 32'hFFFF, '0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, '0);
    for (int i = 0; i <= 6; i++) begin
      rd(32'(i * 4));
      chk("reset_map", last_rd, 32'h0);
    end
    rd(32'h0000_1000);
    chk("unselected_rd", last_rd, 32'h0);
    chk("reset_oe", 32'(gpio_oe_o), 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);

    // Direction/output registers, same-cycle read returns old value
    wr(32'h00, 32'h0000_00FF);
    wr(32'h04, 32'hFFFF_A5A5);
    chk("same_cycle_old", last_rd, 32'h0);
    chk("oe_after_wr", 32'(gpio_oe_o), 32'h00FF);
    chk("out_after_wr", 32'(gpio_o), 32'hA5A5);
    rd(32'h04);
    chk("out_readback", last_rd, 32'h0000_A5A5);
    wr(32'h0000_0100, 32'h0);
    wr(32'h01, 32'h0);
    wr(32'h08, 32'hFFFF);
    rd(32'h00);
    chk("ignored_writes", last_rd, 32'h0000_00FF);

    // Rising edge latency on bit0
    wr(32'h0C, 32'h1);
    wr(32'h10, 32'h0);
    gpio[0] = 1'b1;
    for (int i = 1; i <= 5 + XL; i++) begin
      rd(32'h14);
      chk("is_latency", last_rd, (i >= 4 + XL) ? 32'h1 : 32'h0);
      chk("irq_latency", 32'(irq_o), (i >= 4 + XL) ? 32'h1 : 32'h0);
    end
    wr(32'h14, 32'h1);
    chk("irq_hold_w1c", 32'(irq_o), 32'h1);
    rd(32'h14);
    chk("is_cleared", last_rd, 32'h0);
    chk("irq_cleared", 32'(irq_o), 32'h0);

    // Falling-edge mode on bit1
    wr(32'h10, 32'h2);
    gpio[1] = 1'b1;
    for (int i = 0; i < 4 + XL; i++) rd(32'h14);
    chk("fall_mode_rise", last_rd, 32'h0);
    gpio[1] = 1'b0;
    for (int i = 0; i < 4 + XL; i++) rd(32'h14);
    chk("fall_mode_fall", last_rd, 32'h2);
    wr(32'h14, 32'hFFFF);

    // W1C colliding with a new rise event on bit0
    gpio[0] = 1'b0;
    for (int i = 0; i < 4 + XL; i++) rd(32'h08);
    gpio[0] = 1'b1;
    for (int i = 0; i < 4 + XL; i++) rd(32'h14);
    chk("is_set_again", last_rd, 32'h1);
    gpio[0] = 1'b0;
    for (int i = 0; i < 4 + XL; i++) rd(32'h14);
    gpio[0] = 1'b1;
    for (int i = 0; i < 2 + XL; i++) rd(32'h14);
    wr(32'h14, 32'h1);
    chk("collide_irq", 32'(irq_o), 32'h1);
    rd(32'h14);
    chk("collide_is", last_rd, 32'h1);
    chk("collide_irq2", 32'(irq_o), 32'h1);
    wr(32'h14, 32'hFFFF);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch filtered, long pulse accepted
    wr(32'h10, 32'h0);
    gpio[2] = 1'b1;
    for (int i = 0; i < 5; i++) rd(32'h08);
    gpio[2] = 1'b0;
    for (int i = 0; i < 20; i++) rd(32'h14);
    chk("glitch_is", last_rd & 32'h4, 32'h0);
    gpio[2] = 1'b1;
    for (int i = 0; i < 12; i++) rd(32'h14);
    chk("long_is", last_rd & 32'h4, 32'h4);
    rd(32'h08);
    chk("long_in", last_rd & 32'h4, 32'h4);
`endif

    // Randomized traffic against the model
    g = gpio;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) ra = 32'($urandom_range(0, 7) * 4);
      else ra = $urandom & 32'h0FFF_01FF;
      if ($urandom_range(0, 3) == 0) g = g ^ (N'($urandom) & N'($urandom) & N'($urandom));
      cycle(($urandom_range(0, 63) != 0), ra, 1'($urandom), $urandom, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
